// File: rtl/fp_add_pkg.sv
// Shared widths, operand layout and field helpers for the shared fp_adder scheduler.
// The operand is {sign, exp[3:0], frac[7:0]}.
package fp_add_pkg;

    localparam int FP_W   = 13;
    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp13_t;

    function automatic fp13_t fp_unpack(input logic [FP_W-1:0] raw);
        fp13_t f;
        f.sign = raw[FP_W-1];
        f.exp  = raw[FP_W-2:FRAC_W];
        f.frac = raw[FRAC_W-1:0];
        return f;
    endfunction

    function automatic logic [FP_W-1:0] fp_join(input logic              sign,
                                                input logic [EXP_W-1:0]  exp,
                                                input logic [FRAC_W-1:0] frac);
        return {sign, exp, frac};
    endfunction

endpackage

// File: rtl/fp_res_fifo.sv
// Result FIFO with a registered head view: data_o holds the last head while empty.
// Push and pop in the same cycle are both honoured.
module fp_res_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic                         valid_o,
    output logic [WIDTH-1:0]             data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d, remain_s;
    logic [WIDTH-1:0] head_q, head_d;
    logic             full_s, wr_en_s, rd_en_s;

    // Next pointers, occupancy and the head entry visible after this edge
    always_comb begin
        full_s   = (count_q == CW'(DEPTH));
        wr_en_s  = push_i & (~full_s | pop_i);
        rd_en_s  = pop_i & (count_q != {CW{1'b0}});
        remain_s = count_q - CW'(rd_en_s);
        count_d  = remain_s + CW'(wr_en_s);
        rd_ptr_d = rd_ptr_q + AW'(rd_en_s);
        wr_ptr_d = wr_ptr_q + AW'(wr_en_s);
        if (count_d == {CW{1'b0}}) begin
            head_d = head_q;
        end else if (remain_s == {CW{1'b0}}) begin
            head_d = data_i;
        end else begin
            head_d = mem_q[rd_ptr_d];
        end
    end

    // Storage array; contents are meaningless outside the occupied window
    always_ff @(posedge clk_i) begin
        if (wr_en_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Pointers, count and head register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_q <= {AW{1'b0}};
            wr_ptr_q <= {AW{1'b0}};
            count_q  <= {CW{1'b0}};
            head_q   <= {WIDTH{1'b0}};
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

    assign valid_o = (count_q != {CW{1'b0}});
    assign data_o  = head_q;
    assign count_o = count_q;

endmodule

// File: rtl/fp_add_sched.sv
// Round-robin, credit-gated scheduler sharing one registered fp_adder among N clients.
// Sums come back through fp_res_fifo tagged with the requester id, in issue order.
module fp_add_sched
    import fp_add_pkg::*;
#(
    parameter int N          = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IDW        = $clog2(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N*FP_W-1:0]   op_a,
    input  logic [N*FP_W-1:0]   op_b,
    output logic [N-1:0]        ack,
    output logic                add_sign1,
    output logic                add_sign2,
    output logic [EXP_W-1:0]    add_exp1,
    output logic [EXP_W-1:0]    add_exp2,
    output logic [FRAC_W-1:0]   add_frac1,
    output logic [FRAC_W-1:0]   add_frac2,
    input  logic                add_sign_out,
    input  logic [EXP_W-1:0]    add_exp_out,
    input  logic [FRAC_W-1:0]   add_frac_out,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [FP_W-1:0]     res_data,
    output logic [IDW-1:0]      res_id
);

    localparam int CW = $clog2(FIFO_DEPTH+1);

    logic [IDW-1:0]       ptr_q, ptr_d, grant_s;
    logic [IDW-1:0]       s1_id_q, s2_id_q;
    logic                 s1_v_q, s2_v_q;
    logic                 grant_v_s, credit_ok_s, issue_s;
    logic [CW:0]          occ_s;
    logic [CW-1:0]        fifo_count_s;
    fp13_t                add_a_q, add_a_d, add_b_q, add_b_d;
    logic [FP_W+IDW-1:0]  fifo_wdata_s, fifo_rdata_s;
    logic                 fifo_pop_s;
    int                   idx_s;

    // Credit counts every op that will eventually land in the FIFO; a same-cycle pop is not credited
    always_comb begin
        occ_s       = {1'b0, fifo_count_s} + (CW+1)'(s1_v_q) + (CW+1)'(s2_v_q);
        credit_ok_s = (occ_s < (CW+1)'(FIFO_DEPTH));
        grant_s     = {IDW{1'b0}};
        grant_v_s   = 1'b0;
        idx_s       = 0;
        for (int k = N-1; k >= 0; k--) begin
            idx_s = (int'(ptr_q) + k) % N;
            if (req[idx_s]) begin
                grant_s   = IDW'(idx_s);
                grant_v_s = 1'b1;
            end else begin
                grant_v_s = grant_v_s;
            end
        end
        issue_s = grant_v_s & credit_ok_s & ~rst;
        if (grant_s == IDW'(N-1)) begin
            ptr_d = {IDW{1'b0}};
        end else begin
            ptr_d = grant_s + IDW'(1);
        end
        add_a_d = fp_unpack(op_a[int'(grant_s)*FP_W +: FP_W]);
        add_b_d = fp_unpack(op_b[int'(grant_s)*FP_W +: FP_W]);
    end

    // One-hot acknowledge of the granted requester
    always_comb begin
        ack = {N{1'b0}};
        if (issue_s) begin
            ack[grant_s] = 1'b1;
        end else begin
            ack = {N{1'b0}};
        end
    end

    // Operand registers hold their value between issues so the adder inputs do not toggle
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q   <= {IDW{1'b0}};
            s1_v_q  <= 1'b0;
            s2_v_q  <= 1'b0;
            s1_id_q <= {IDW{1'b0}};
            s2_id_q <= {IDW{1'b0}};
            add_a_q <= '0;
            add_b_q <= '0;
        end else begin
            s1_v_q  <= issue_s;
            s2_v_q  <= s1_v_q;
            s2_id_q <= s1_id_q;
            if (issue_s) begin
                ptr_q   <= ptr_d;
                s1_id_q <= grant_s;
                add_a_q <= add_a_d;
                add_b_q <= add_b_d;
            end
        end
    end

    assign add_sign1 = add_a_q.sign;
    assign add_exp1  = add_a_q.exp;
    assign add_frac1 = add_a_q.frac;
    assign add_sign2 = add_b_q.sign;
    assign add_exp2  = add_b_q.exp;
    assign add_frac2 = add_b_q.frac;

    assign fifo_wdata_s = {fp_join(add_sign_out, add_exp_out, add_frac_out), s2_id_q};
    assign fifo_pop_s   = res_valid & res_ready;

    fp_res_fifo #(
        .WIDTH (FP_W + IDW),
        .DEPTH (FIFO_DEPTH)
    ) u_res_fifo (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (s2_v_q),
        .data_i  (fifo_wdata_s),
        .pop_i   (fifo_pop_s),
        .valid_o (res_valid),
        .data_o  (fifo_rdata_s),
        .count_o (fifo_count_s)
    );

    assign res_data = fifo_rdata_s[FP_W+IDW-1:IDW];
    assign res_id   = fifo_rdata_s[IDW-1:0];

endmodule

// File: tb/tb_fp_add_sched.sv
// Bench for fp_add_sched: a registered behavioural adder stands in for fp_adder, and a
// queue-based model predicts acks, result order, latency and credit stalls.
module tb_fp_add_sched;

    localparam int N   = 4;
    localparam int D   = 4;
    localparam int IDW = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req;
    logic [N*13-1:0]  op_a, op_b;
    logic [N-1:0]     ack;
    logic             add_sign1, add_sign2;
    logic [3:0]       add_exp1, add_exp2;
    logic [7:0]       add_frac1, add_frac2;
    logic [12:0]      adder_q;
    logic             res_valid, res_ready;
    logic [12:0]      res_data;
    logic [IDW-1:0]   res_id;

    always #5 clk = ~clk;

    fp_add_sched #(.N(N), .FIFO_DEPTH(D), .IDW(IDW)) dut (
        .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b), .ack(ack),
        .add_sign1(add_sign1), .add_sign2(add_sign2),
        .add_exp1(add_exp1), .add_exp2(add_exp2),
        .add_frac1(add_frac1), .add_frac2(add_frac2),
        .add_sign_out(adder_q[12]), .add_exp_out(adder_q[11:8]), .add_frac_out(adder_q[7:0]),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id)
    );

    // Hidden-bit float add, truncating; stands in for the external fp_adder
    function automatic logic [12:0] fpadd(input logic [12:0] a, input logic [12:0] b);
        int ea, eb, ma, mb, e, m, t;
        logic sa, sb, ts;
        sa = a[12]; ea = int'(a[11:8]); ma = 256 + int'(a[7:0]);
        sb = b[12]; eb = int'(b[11:8]); mb = 256 + int'(b[7:0]);
        if (eb > ea || (eb == ea && mb > ma)) begin
            t = ea; ea = eb; eb = t;
            t = ma; ma = mb; mb = t;
            ts = sa; sa = sb; sb = ts;
        end
        mb = mb >> (ea - eb);
        e = ea;
        if (sa == sb) begin
            m = ma + mb;
            if (m >= 512) begin m = m >> 1; e = e + 1; end
            if (e > 15) return {sa, 4'hF, 8'hFF};
        end else begin
            m = ma - mb;
            if (m == 0) return 13'h0000;
            while (m < 256 && e > 0) begin m = m << 1; e = e - 1; end
        end
        return {sa, e[3:0], m[7:0]};
    endfunction

    always @(posedge clk) adder_q <= fpadd({add_sign1, add_exp1, add_frac1}, {add_sign2, add_exp2, add_frac2});

    typedef struct { logic [12:0] data; logic [IDW-1:0] id; int avail; } item_t;
    item_t           q[$];
    int              ptr_m = 0, issued = 0, popped = 0, edge_n = 0, exp_g;
    logic [N-1:0]    exp_ack;
    logic            exp_valid;
    logic [12:0]     exp_data, last_data = 13'h0000;
    logic [IDW-1:0]  exp_id, last_id = 2'd0;
    bit              auto_clear = 1'b0;
    int              checks = 0, passed = 0;

    task automatic eval_model();
        #1;
        exp_ack = '0;
        exp_g   = -1;
        if (!rst && (issued - popped) < D) begin
            for (int k = 0; k < N; k++)
                if (exp_g < 0 && req[(ptr_m + k) % N]) exp_g = (ptr_m + k) % N;
        end
        if (exp_g >= 0) exp_ack[exp_g] = 1'b1;
        exp_valid = (q.size() > 0) && (q[0].avail <= edge_n);
        exp_data  = exp_valid ? q[0].data : last_data;
        exp_id    = exp_valid ? q[0].id   : last_id;
    endtask

    task automatic advance();
        logic [12:0] a, b;
        if (rst) begin
            q.delete(); ptr_m = 0; issued = 0; popped = 0;
            last_data = 13'h0000; last_id = 2'd0;
        end else begin
            if (exp_valid) begin last_data = exp_data; last_id = exp_id; end
            if (exp_valid && res_ready) begin q.delete(0); popped++; end
            if (exp_g >= 0) begin
                a = op_a[13*exp_g +: 13];
                b = op_b[13*exp_g +: 13];
                q.push_back('{data: fpadd(a, b), id: IDW'(exp_g), avail: edge_n + 3});
                issued++;
                ptr_m = (exp_g + 1) % N;
            end
        end
        @(posedge clk);
        edge_n++;
        @(negedge clk);
        if (auto_clear) req = req & ~exp_ack;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            op_a[13*i +: 13] = 13'($urandom());
            op_b[13*i +: 13] = 13'($urandom());
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0;
        eval_model(); advance();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '1; res_ready = 1'b1; rand_ops();
        eval_model();
        checks++; if (ack !== 4'b0000) $display("FAIL reset_ack0: got %b want 0000", ack); else passed++;
        advance();
        eval_model();
        checks++; if (ack !== 4'b0000) $display("FAIL reset_ack1: got %b want 0000", ack); else passed++;
        checks++; if ({add_sign1, add_exp1, add_frac1, add_sign2, add_exp2, add_frac2} !== 26'd0)
            $display("FAIL reset_add: got %h want 0", {add_sign1, add_exp1, add_frac1, add_sign2, add_exp2, add_frac2}); else passed++;
        checks++; if ({res_valid, res_data, res_id} !== 16'd0)
            $display("FAIL reset_res: got v=%b d=%h id=%0d want all 0", res_valid, res_data, res_id); else passed++;
        advance();
        rst = 1'b0; req = '0;
    endtask

    task automatic test_single_op();
        int ack_cyc = -1, acks = 0;
        bit seen = 1'b0;
        auto_clear = 1'b1; res_ready = 1'b1;
        op_a[13 +: 13] = 13'h0380; op_b[13 +: 13] = 13'h0380;
        req = 4'b0010;
        for (int c = 0; c < 8; c++) begin
            eval_model();
            checks++; if (ack !== exp_ack) $display("FAIL single_ack: got %b want %b", ack, exp_ack); else passed++;
            checks++; if (res_valid !== exp_valid) $display("FAIL single_valid: got %b want %b", res_valid, exp_valid); else passed++;
            checks++; if ({res_data, res_id} !== {exp_data, exp_id}) $display("FAIL single_data: got %h/%0d want %h/%0d", res_data, res_id, exp_data, exp_id); else passed++;
            if (ack[1]) begin acks++; ack_cyc = c; end
            if (res_valid && !seen) begin
                seen = 1'b1;
                checks++; if (c - ack_cyc != 3) $display("FAIL single_latency: got %0d want 3", c - ack_cyc); else passed++;
                checks++; if (res_data !== 13'h0480 || res_id !== 2'd1)
                    $display("FAIL single_result: got %h/%0d want 0480/1", res_data, res_id); else passed++;
            end
            advance();
        end
        checks++; if (acks != 1 || !seen) $display("FAIL single_count: got acks=%0d seen=%0d want 1/1", acks, seen); else passed++;
    endtask

    task automatic test_round_robin();
        int n = 0, idx;
        do_reset();
        auto_clear = 1'b0; res_ready = 1'b1; req = 4'b1111;
        for (int c = 0; c < 14; c++) begin
            rand_ops();
            eval_model();
            checks++; if (ack !== exp_ack) $display("FAIL rr_ack: got %b want %b", ack, exp_ack); else passed++;
            checks++; if (res_valid !== exp_valid) $display("FAIL rr_valid: got %b want %b", res_valid, exp_valid); else passed++;
            checks++; if ({res_data, res_id} !== {exp_data, exp_id}) $display("FAIL rr_data: got %h/%0d want %h/%0d", res_data, res_id, exp_data, exp_id); else passed++;
            idx = -1;
            for (int i = 0; i < N; i++) if (ack[i]) idx = i;
            checks++; if (idx != n % N) $display("FAIL rr_order: got %0d want %0d", idx, n % N); else passed++;
            n++;
            advance();
        end
        req = '0;
    endtask

    task automatic test_backpressure();
        int acks = 0;
        bit held = 1'b0;
        logic [12:0] hold_d;
        do_reset();
        auto_clear = 1'b0; res_ready = 1'b0; req = 4'b0001;
        for (int c = 0; c < 12; c++) begin
            rand_ops();
            eval_model();
            checks++; if (ack !== exp_ack) $display("FAIL bp_ack: got %b want %b", ack, exp_ack); else passed++;
            checks++; if (res_valid !== exp_valid) $display("FAIL bp_valid: got %b want %b", res_valid, exp_valid); else passed++;
            if (res_valid && !held) begin held = 1'b1; hold_d = res_data; end
            else if (held) begin
                checks++; if (res_data !== hold_d) $display("FAIL bp_stable: got %h want %h", res_data, hold_d); else passed++;
            end
            if (ack != '0) acks++;
            advance();
        end
        checks++; if (acks != 4) $display("FAIL bp_acks: got %0d want 4", acks); else passed++;
        res_ready = 1'b1;
        eval_model();
        checks++; if (ack !== 4'b0000) $display("FAIL bp_pulse_ack: got %b want 0000", ack); else passed++;
        advance();
        res_ready = 1'b0;
        eval_model();
        checks++; if (ack !== 4'b0001) $display("FAIL bp_reopen: got %b want 0001", ack); else passed++;
        advance();
        req = '0; res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            eval_model();
            checks++; if ({res_valid, res_data, res_id} !== {exp_valid, exp_data, exp_id})
                $display("FAIL bp_drain: got %b/%h/%0d want %b/%h/%0d", res_valid, res_data, res_id, exp_valid, exp_data, exp_id); else passed++;
            advance();
        end
    endtask

    task automatic test_subtract();
        bit seen = 1'b0;
        auto_clear = 1'b1; res_ready = 1'b1;
        op_a[26 +: 13] = 13'h05C0; op_b[26 +: 13] = 13'h1540;
        req = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            eval_model();
            checks++; if (ack !== exp_ack) $display("FAIL sub_ack: got %b want %b", ack, exp_ack); else passed++;
            if (res_valid && !seen) begin
                seen = 1'b1;
                checks++; if (res_data !== fpadd(13'h05C0, 13'h1540) || res_id !== 2'd2)
                    $display("FAIL sub_result: got %h/%0d want %h/2", res_data, res_id, fpadd(13'h05C0, 13'h1540)); else passed++;
            end
            advance();
        end
        checks++; if (!seen) $display("FAIL sub_seen: got 0 want 1"); else passed++;
    endtask

    task automatic test_random_stream();
        auto_clear = 1'b1;
        for (int c = 0; c < 400; c++) begin
            rand_ops();
            req = req | 4'($urandom() & $urandom());
            if ($urandom_range(0, 9) == 0) req[$urandom_range(0, N-1)] = 1'b0;
            res_ready = ($urandom_range(0, 3) != 0);
            eval_model();
            checks++; if (ack !== exp_ack) $display("FAIL rand_ack: got %b want %b", ack, exp_ack); else passed++;
            checks++; if ({res_valid, res_data, res_id} !== {exp_valid, exp_data, exp_id})
                $display("FAIL rand_res: got %b/%h/%0d want %b/%h/%0d", res_valid, res_data, res_id, exp_valid, exp_data, exp_id); else passed++;
            advance();
        end
        req = '0;
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        auto_clear = 1'b1; res_ready = 1'b0; req = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            rand_ops();
            eval_model();
            checks++; if (ack !== exp_ack) $display("FAIL rmo_fill: got %b want %b", ack, exp_ack); else passed++;
            advance();
        end
        rst = 1'b1;
        eval_model();
        checks++; if (res_valid !== 1'b1 || ack !== 4'b0000) $display("FAIL rmo_pre: got v=%b ack=%b want 1/0000", res_valid, ack); else passed++;
        advance();
        rst = 1'b0; res_ready = 1'b1;
        eval_model();
        checks++; if ({res_valid, res_data, res_id} !== 16'd0 ||
                      {add_sign1, add_exp1, add_frac1, add_sign2, add_exp2, add_frac2} !== 26'd0)
            $display("FAIL rmo_clear: got v=%b d=%h id=%0d want all 0", res_valid, res_data, res_id); else passed++;
        for (int c = 0; c < 8; c++) begin
            checks++; if (res_valid !== 1'b0) $display("FAIL rmo_stale: got %b want 0", res_valid); else passed++;
            advance();
            eval_model();
        end
        req = 4'b1111;
        eval_model();
        checks++; if (ack !== 4'b0001) $display("FAIL rmo_ptr: got %b want 0001", ack); else passed++;
        advance();
        req = '0;
        for (int c = 0; c < 6; c++) begin
            eval_model();
            checks++; if ({res_valid, res_data, res_id} !== {exp_valid, exp_data, exp_id})
                $display("FAIL rmo_after: got %b/%h/%0d want %b/%h/%0d", res_valid, res_data, res_id, exp_valid, exp_data, exp_id); else passed++;
            advance();
        end
    endtask

    initial begin
        rst = 1'b1; req = '0; res_ready = 1'b1; op_a = '0; op_b = '0;
        @(negedge clk);
        test_reset();
        test_single_op();
        test_round_robin();
        test_backpressure();
        test_subtract();
        test_random_stream();
        test_reset_mid_op();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
